// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding shared by the stage sequencer, its datapath top and the bench
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXECUTE) ||
               (s == ST_MEMORY) || (s == ST_WRITEBACK);
    endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// rtl/stage_sequencer_wait_timer.sv - loadable saturating up-counter with clear and timeout flag
module wait_timer #(
    parameter int W     = 5,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    // Flags the cycle that would be the LIMIT-th consecutive unacknowledged one.
    assign o_expire = (r_count >= W'(LIMIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage sequencer FSM; SEQ_PERF_CNT_EN adds retired/stall counters
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int MAX_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             mem_access,
    input  logic             reg_write,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_busy, r_imem_req, r_dmem_req, r_decode_en, r_execute_en;
    logic             r_pc_en, r_halted, r_error;
    logic [CNT_W-1:0] r_cycle;
    logic             w_waiting, w_expire, w_limit;

    assign w_waiting = ((r_state == ST_FETCH) && !imem_ack) ||
                       ((r_state == ST_MEMORY) && !dmem_ack);

    // Limit is checked against the count before this WRITEBACK cycle is added.
    assign w_limit = (MAX_CYCLES != 0) && (r_cycle >= CNT_W'(MAX_CYCLES - 1));

    wait_timer #(.W(WAIT_W), .LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (!w_waiting),
        .i_inc      (w_waiting),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_FETCH;
            ST_FETCH:     if (imem_ack) w_next = ST_DECODE;
                          else if (w_expire) w_next = ST_ERROR;
            ST_DECODE:    w_next = ST_EXECUTE;
            ST_EXECUTE:   w_next = mem_access ? ST_MEMORY : ST_WRITEBACK;
            ST_MEMORY:    if (dmem_ack) w_next = ST_WRITEBACK;
                          else if (w_expire) w_next = ST_ERROR;
            ST_WRITEBACK: w_next = (halt_req || w_limit) ? ST_HALT : ST_FETCH;
            default:      w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_execute_en <= 1'b0;
            r_pc_en      <= 1'b0;
            r_halted     <= 1'b0;
            r_error      <= 1'b0;
            r_cycle      <= '0;
        end else begin
            r_state      <= w_next;
            r_busy       <= is_busy(w_next);
            r_imem_req   <= (w_next == ST_FETCH);
            r_dmem_req   <= (w_next == ST_MEMORY);
            r_decode_en  <= (w_next == ST_DECODE);
            r_execute_en <= (w_next == ST_EXECUTE);
            r_pc_en      <= (w_next == ST_WRITEBACK);
            r_halted     <= (w_next == ST_HALT);
            r_error      <= (w_next == ST_ERROR);
            if (r_busy && (r_cycle != '1)) r_cycle <= r_cycle + CNT_W'(1);
        end
    end

    assign imem_req     = r_imem_req;
    assign dmem_req     = r_dmem_req;
    assign decode_en    = r_decode_en;
    assign execute_en   = r_execute_en;
    assign pc_en        = r_pc_en;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign error        = r_error;
    assign cycle_count  = r_cycle;

    // Ack-qualified enables fire in the acknowledging cycle to keep 4/5-cycle latency.
    assign fetch_en     = !reset && (r_state == ST_FETCH) && imem_ack;
    assign memory_en    = !reset && (r_state == ST_MEMORY) && dmem_ack;
    assign writeback_en = !reset && (r_state == ST_WRITEBACK) && reg_write;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_retired, r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if ((r_state == ST_WRITEBACK) && (r_retired != '1)) r_retired <= r_retired + CNT_W'(1);
            if (w_waiting && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign retired_count = r_retired;
    assign stall_count   = r_stall;
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer (three parameter sets)
module tb_stage_sequencer;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, halt_req, mem_access, reg_write, imem_ack, dmem_ack;
    logic [2:0] imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en;
    logic [2:0] writeback_en, pc_en, busy, halted, error;
    logic [31:0] cyc [3];
    logic [31:0] ret [3];
    logic [31:0] stl [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: MEM_TIMEOUT=4; 2: MAX_CYCLES=10.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        stage_sequencer #(
            .CNT_W       (32),
            .MEM_TIMEOUT (g == 1 ? 4 : 16),
            .MAX_CYCLES  (g == 2 ? 10 : 0)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start),
            .halt_req      (halt_req),
            .mem_access    (mem_access),
            .reg_write     (reg_write),
            .imem_ack      (imem_ack),
            .dmem_ack      (dmem_ack),
            .imem_req      (imem_req[g]),
            .dmem_req      (dmem_req[g]),
            .fetch_en      (fetch_en[g]),
            .decode_en     (decode_en[g]),
            .execute_en    (execute_en[g]),
            .memory_en     (memory_en[g]),
            .writeback_en  (writeback_en[g]),
            .pc_en         (pc_en[g]),
            .busy          (busy[g]),
            .halted        (halted[g]),
            .error         (error[g]),
            .cycle_count   (cyc[g]),
            .retired_count (ret[g]),
            .stall_count   (stl[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Runs from IDLE until instance inst halts/errors; acks come after the given wait cycles.
    task automatic run_prog(input int inst, input int imem_delay, input int dmem_delay,
                            input int halt_on_wb, output int nbusy, output int nwb,
                            output int nfetch, output int nmem, output int nviol,
                            output bit timed_out);
        int icyc, mcyc, iter;
        nbusy = 0; nwb = 0; nfetch = 0; nmem = 0; nviol = 0; icyc = 0; mcyc = 0; iter = 0;
        timed_out = 1'b0;
        start = 1'b1; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        forever begin
            step();
            start = 1'b0;
            if (halted[inst] || error[inst]) break;
            if (iter >= 200) begin timed_out = 1'b1; break; end
            iter++;
            if (busy[inst]) nbusy++;
            if (imem_req[inst]) begin icyc++; imem_ack = (icyc > imem_delay); end
            else begin icyc = 0; imem_ack = 1'b0; end
            if (dmem_req[inst]) begin mcyc++; dmem_ack = (mcyc > dmem_delay); end
            else begin mcyc = 0; dmem_ack = 1'b0; end
            if (pc_en[inst]) begin nwb++; halt_req = (nwb == halt_on_wb); end
            else halt_req = 1'b0;
            #1;
            if (fetch_en[inst]) nfetch++;
            if (memory_en[inst]) nmem++;
            if ($countones({fetch_en[inst], decode_en[inst], execute_en[inst],
                            memory_en[inst], writeback_en[inst]}) > 1) nviol++;
            if (pc_en[inst] && (writeback_en[inst] !== reg_write)) nviol++;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; halt_req = 1'b1;
        mem_access = 1'b0; reg_write = 1'b1;
        step();
        checks++; if ({busy, halted, error, imem_req} !== 12'h0) begin failures++;
            $display("FAIL reset_status got=%h exp=0", {busy, halted, error, imem_req}); end
        checks++; if ({cyc[0], ret[0], stl[0]} !== 96'h0) begin failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cyc[0], ret[0], stl[0]); end
        reset = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
        step();
        checks++; if (busy !== 3'b000) begin failures++;
            $display("FAIL reset_overrides_start busy=%b exp=000", busy); end
    endtask

    task automatic test_basic_run();
        int nb, nw, nf, nm, nv; bit to;
        do_reset(); mem_access = 1'b0; reg_write = 1'b1;
        run_prog(0, 0, 0, 3, nb, nw, nf, nm, nv, to);
        checks++; if (to || nb != 12) begin failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=12 timeout=%0b", nb, to); end
        checks++; if (halted[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++;
            $display("FAIL basic_halted got=%b busy=%b exp=1/0", halted[0], busy[0]); end
        checks++; if (cyc[0] !== 32'd12) begin failures++;
            $display("FAIL basic_cycle_count got=%0d exp=12", cyc[0]); end
        checks++; if (ret[0] !== (PERF ? 32'd3 : 32'd0)) begin failures++;
            $display("FAIL basic_retired got=%0d exp=%0d", ret[0], PERF ? 3 : 0); end
        checks++; if (stl[0] !== 32'd0) begin failures++;
            $display("FAIL basic_stall got=%0d exp=0", stl[0]); end
        checks++; if (nw != 3 || nf != 3 || nm != 0 || nv != 0) begin failures++;
            $display("FAIL basic_enables wb=%0d fetch=%0d mem=%0d viol=%0d exp=3/3/0/0", nw, nf, nm, nv); end
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (3) step();
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        checks++; if (halted[0] !== 1'b1 || imem_req[0] !== 1'b0 || fetch_en[0] !== 1'b0 || cyc[0] !== 32'd12) begin
            failures++; $display("FAIL halt_absorbing halted=%b req=%b fen=%b cyc=%0d exp=1/0/0/12",
                                 halted[0], imem_req[0], fetch_en[0], cyc[0]); end
    endtask

    task automatic test_mem_stall();
        int nb, nw, nf, nm, nv; bit to;
        do_reset(); mem_access = 1'b1; reg_write = 1'b0;
        run_prog(0, 0, 3, 1, nb, nw, nf, nm, nv, to);
        checks++; if (to || nb != 8) begin failures++;
            $display("FAIL mem_busy_cycles got=%0d exp=8 timeout=%0b", nb, to); end
        checks++; if (nm != 1 || nv != 0) begin failures++;
            $display("FAIL mem_enable_pulses got=%0d viol=%0d exp=1/0", nm, nv); end
        checks++; if (stl[0] !== (PERF ? 32'd3 : 32'd0) || cyc[0] !== 32'd8) begin failures++;
            $display("FAIL mem_counters stall=%0d cyc=%0d exp=%0d/8", stl[0], cyc[0], PERF ? 3 : 0); end
    endtask

    task automatic test_timeout();
        int nb, nw, nf, nm, nv; bit to;
        do_reset(); mem_access = 1'b0; reg_write = 1'b1;
        run_prog(1, 1000, 0, 1, nb, nw, nf, nm, nv, to);
        checks++; if (to || nb != 4 || error[1] !== 1'b1) begin failures++;
            $display("FAIL timeout_error fetch_cycles=%0d err=%b exp=4/1", nb, error[1]); end
        imem_ack = 1'b1; start = 1'b1;
        repeat (2) step();
        imem_ack = 1'b0; start = 1'b0;
        checks++; if (error[1] !== 1'b1 || imem_req[1] !== 1'b0 || busy[1] !== 1'b0 || fetch_en[1] !== 1'b0) begin
            failures++; $display("FAIL error_absorbing err=%b req=%b busy=%b exp=1/0/0", error[1], imem_req[1], busy[1]); end
        checks++; if (stl[1] !== (PERF ? 32'd4 : 32'd0)) begin failures++;
            $display("FAIL timeout_stall got=%0d exp=%0d", stl[1], PERF ? 4 : 0); end
        do_reset();
        run_prog(1, 3, 0, 1, nb, nw, nf, nm, nv, to);
        checks++; if (to || error[1] !== 1'b0 || halted[1] !== 1'b1 || nb != 7) begin failures++;
            $display("FAIL ack_beats_timeout err=%b halted=%b busy=%0d exp=0/1/7", error[1], halted[1], nb); end
    endtask

    task automatic test_run_limit();
        int nb, nw, nf, nm, nv; bit to;
        do_reset(); mem_access = 1'b0; reg_write = 1'b1;
        run_prog(2, 0, 0, 0, nb, nw, nf, nm, nv, to);
        checks++; if (to || nb != 12 || nw != 3) begin failures++;
            $display("FAIL limit_cycles busy=%0d wb=%0d exp=12/3", nb, nw); end
        checks++; if (halted[2] !== 1'b1 || cyc[2] !== 32'd12) begin failures++;
            $display("FAIL limit_halt halted=%b cyc=%0d exp=1/12", halted[2], cyc[2]); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset(); mem_access = 1'b1; reg_write = 1'b1;
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
        step(); start = 1'b0;
        n = 0;
        while (!dmem_req[0] && n < 20) begin step(); n++; end
        start = 1'b1; imem_ack = 1'b1;
        repeat (2) step();
        checks++; if (dmem_req[0] !== 1'b1 || imem_req[0] !== 1'b0 || busy[0] !== 1'b1) begin failures++;
            $display("FAIL start_while_busy dreq=%b ireq=%b busy=%b exp=1/0/1", dmem_req[0], imem_req[0], busy[0]); end
        reset = 1'b1; dmem_ack = 1'b1; halt_req = 1'b1;
        step();
        checks++; if (busy[0] !== 1'b0 || dmem_req[0] !== 1'b0 || memory_en[0] !== 1'b0 ||
                      cyc[0] !== 32'd0 || stl[0] !== 32'd0 || ret[0] !== 32'd0) begin failures++;
            $display("FAIL reset_mid_wait busy=%b dreq=%b cyc=%0d stall=%0d exp=0/0/0/0",
                     busy[0], dmem_req[0], cyc[0], stl[0]); end
        reset = 1'b0; start = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        step();
        checks++; if (busy[0] !== 1'b0 || imem_req[0] !== 1'b0) begin failures++;
            $display("FAIL idle_after_reset busy=%b ireq=%b exp=0/0", busy[0], imem_req[0]); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_access = 1'b0;
        reg_write = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        test_reset();
        test_basic_run();
        test_mem_stall();
        test_timeout();
        test_run_limit();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter: CNT_W, default 32, width of cycle and performance counters.
REQ-002 Parameter: MEM_TIMEOUT, default 16, maximum wait cycles for imem_ack/dmem_ack before error.
REQ-003 Parameter: MAX_CYCLES, default 0, run limit in cycles; 0 means unlimited.
REQ-004 Ports: clk  in  1  single system clock; one clock, all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin execution from IDLE.
REQ-007 halt_req  in  1  decoded halt instruction, sampled in WRITEBACK.
REQ-008 mem_access  in  1  current instruction needs the memory stage (mem_read|mem_write).
REQ-009 reg_write  in  1  current instruction writes the register file.
REQ-010 imem_ack, dmem_ack  in  1 each  memory completion acknowledges.
REQ-011 imem_req, dmem_req  out  1 each  memory requests.
REQ-012 fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables.
REQ-013 busy, halted, error  out  1 each  status.
REQ-014 cycle_count, retired_count, stall_count  out  CNT_W each  counters.

Function
REQ-015 FSM states: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR; at most one stage enable high per cycle.
REQ-016 IDLE: start=1 -> FETCH next cycle; start ignored in every other state.
REQ-017 FETCH: imem_req=1; cycle with imem_ack=1 asserts fetch_en and moves to DECODE; without ack, remain.
REQ-018 DECODE: decode_en=1 for exactly one cycle -> EXECUTE.
REQ-019 EXECUTE: execute_en=1 for one cycle -> MEMORY if mem_access=1, else WRITEBACK.
REQ-020 MEMORY: dmem_req=1; cycle with dmem_ack=1 asserts memory_en -> WRITEBACK.
REQ-021 WRITEBACK: writeback_en=reg_write, pc_en=1, one cycle; then HALT if halt_req=1 or run limit hit, else FETCH.
REQ-022 Minimum latency with same-cycle acks: 4 cycles per non-memory instruction, 5 per memory instruction.
REQ-023 Wait counter counts consecutive unacknowledged cycles in FETCH/MEMORY; reaching MEM_TIMEOUT -> ERROR; a simultaneous ack wins over timeout.
REQ-024 Run limit: MAX_CYCLES!=0 and cycle_count >= MAX_CYCLES-1 in WRITEBACK -> HALT; instruction in flight always completes.
REQ-025 HALT: halted=1; ERROR: error=1; both absorbing until reset; all requests/enables 0.
REQ-026 busy=1 in FETCH..WRITEBACK only.
REQ-027 cycle_count increments each busy cycle, saturating at all ones.
REQ-028 Acks outside FETCH/MEMORY are ignored.

Reset
REQ-029 reset=1 at any clock edge, including mid-instruction or mid-wait: state IDLE, all counters 0, all outputs 0.
REQ-030 reset overrides start, acks and halt_req in the same cycle.

Configuration
REQ-031 Macro SEQ_PERF_CNT_EN defined: retired_count increments in each WRITEBACK cycle and stall_count increments in each unacknowledged FETCH/MEMORY cycle, both saturating.
REQ-032 SEQ_PERF_CNT_EN undefined: retired_count and stall_count tied to 0, no counter registers; cycle_count unaffected.

Structure
REQ-033 Package seq_pkg holds the state enum typedef and state encodings, shared with the datapath top and bench.
REQ-034 One sub-module, wait_timer: loadable up-counter with clear and timeout flag, instantiated once for REQ-023.

Verification
REQ-035 reset 1 cycle, start, acks tied 1, mem_access=0, reg_write=1, halt_req in 3rd WRITEBACK -> 12 busy cycles, halted=1, cycle_count=12, retired_count=3.
REQ-036 mem_access=1, dmem_ack delayed 3 cycles -> instruction takes 8 cycles, memory_en pulses once, stall_count=3.
REQ-037 MEM_TIMEOUT=4, imem_ack held 0 -> ERROR after 4 FETCH cycles, error=1, imem_req=0 afterwards.
REQ-038 MAX_CYCLES=10, acks 1, no halt_req -> halted after 3rd WRITEBACK (cycle 12), instruction not truncated.
REQ-039 reset asserted during MEMORY wait -> next cycle IDLE, counters 0; start while busy has no effect.
REQ-040 Build without SEQ_PERF_CNT_EN, run REQ-035 -> retired_count=0, stall_count=0, cycle_count=12.
